// File: rtl/serial_byte_rx.sv
// rtl/serial_byte_rx.sv - UART-style serial receiver with mid-bit sampling and a one-entry output buffer
module serial_byte_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    accept  = valid_q & data_ready;
    if (accept) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_in) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // A start bit that is high again at mid-bit was only a glitch
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_in) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_in;
          if (idx_q == IDX_LAST) state_d = S_STOP;
          else                   idx_d   = idx_q + BW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        // Stop sample: a load may coincide with an accept, keeping data_valid high
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rx_in) begin
            ferr_d = 1'b1;
          end else if (valid_q && !accept) begin
            ovr_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
